picosoc_mem_arbiter: RTL

Two-port arbiter that shares the single-ported, byte-lane-writable picosoc on-chip RAM between the PicoRV32 native memory interface (port 0) and a second bus master such as a firmware loader or debug/DMA agent (port 1). Each port uses the PicoRV32 valid/ready handshake. The arbiter registers one winning request, drives the RAM's word address, byte write enables and write data for exactly one cycle, and returns the RAM's one-cycle-latency read data with a ready pulse. Out-of-range accesses are absorbed without touching the RAM.

---
 rtl/picosoc_mem_pkg.sv | 14 +
 rtl/picosoc_rr_arb2.sv | 39 +++
 rtl/picosoc_mem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/picosoc_mem_pkg.sv
// Shared definitions for the picosoc RAM arbiter: FSM encoding, port count
// and the default RAM depth.
package picosoc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int NPORTS        = 2;
  localparam int WORDS_DEFAULT = 512;

endpackage

// File: rtl/picosoc_rr_arb2.sv
// Two-requester round-robin grant. The grant is purely combinational from the
// request vector and the remembered last winner; the last winner is updated
// only when the owning transaction is accepted (completes).
module picosoc_rr_arb2
  import picosoc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  input  logic              accept,
  input  logic              accept_id,
  output logic              grant_valid,
  output logic              grant_id
);

  logic last_grant;

  // Pick the single requester, or on a tie the one that did not win last time.
  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  // Remember the last completed winner; port 1 after reset so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= accept_id;
    end
  end

endmodule

// File: rtl/picosoc_mem_arbiter.sv
// Shares the single-ported picosoc RAM between two PicoRV32-style masters.
// One request is latched per access; the RAM is driven for one ISSUE cycle and
// the registered read data is returned with a one-cycle ready pulse in RESP.
// Out-of-range accesses complete with err set and never enable a RAM write.
module picosoc_mem_arbiter
  import picosoc_mem_pkg::*;
#(
  parameter int WORDS  = WORDS_DEFAULT,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_valid,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state, next_state;
  logic              grant_valid, grant_id, grant;
  logic              port_q, oor_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       sel_addr, sel_wdata;
  logic [3:0]        sel_wstrb;
  logic [ADDR_W-1:0] sel_word;
  logic              sel_oor;
  logic              unused_addr_bits;

  picosoc_rr_arb2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         ({m1_valid, m0_valid}),
    .accept      (state == RESP),
    .accept_id   (port_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Select the winning request and classify its address as in or out of range.
  always_comb begin
    sel_addr  = grant_id ? m1_addr  : m0_addr;
    sel_wdata = grant_id ? m1_wdata : m0_wdata;
    sel_wstrb = grant_id ? m1_wstrb : m0_wstrb;
    sel_word  = sel_addr[ADDR_W+1:2];
    sel_oor   = (32'(sel_word) >= 32'(WORDS)) || (|sel_addr[31:ADDR_W+2]);
  end

  // Byte offset within a word has no meaning for a word-wide RAM.
  assign unused_addr_bits = ^sel_addr[1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the RESP-cycle completion outputs.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_rdata   = 32'h0;
    m1_rdata   = 32'h0;
    m0_err     = 1'b0;
    m1_err     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          grant      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = RESP;
      RESP: begin
        next_state = IDLE;
        if (port_q) begin
          m1_ready = 1'b1;
          m1_err   = oor_q;
          m1_rdata = (!oor_q && wstrb_q == 4'b0000) ? mem_rdata : 32'h0;
        end else begin
          m0_ready = 1'b1;
          m0_err   = oor_q;
          m0_rdata = (!oor_q && wstrb_q == 4'b0000) ? mem_rdata : 32'h0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the granted request; RAM controls are registered so they are valid
  // for exactly the ISSUE cycle, with wen cleared again on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_q    <= 1'b0;
      oor_q     <= 1'b0;
      wstrb_q   <= 4'b0000;
      mem_wen   <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
    end else begin
      mem_wen <= 4'b0000;
      if (grant) begin
        port_q    <= grant_id;
        oor_q     <= sel_oor;
        wstrb_q   <= sel_wstrb;
        mem_addr  <= sel_word;
        mem_wdata <= sel_wdata;
        mem_wen   <= sel_oor ? 4'b0000 : sel_wstrb;
      end
    end
  end

endmodule
